// File: rtl/time_core_hms.sv
// Hours/minutes/seconds time core with a two-stage step pipeline, in BCD.
// It supports 24-hour or 12-hour display, field-wise adjust, and an end-of-day pulse.
`timescale 1ns/1ps

module time_core_hms #(
  parameter bit H24 = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_count_enable,
  input  logic       i_adjust,
  input  logic [1:0] i_adj_field,
  input  logic       i_adj_down,
  input  logic       i_clear_sec,
  output logic [3:0] o_hr_tens,
  output logic [3:0] o_hr_ones,
  output logic [3:0] o_min_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_sec_ones,
  output logic       o_pm,
  output logic       o_day_pulse
);

  typedef enum logic [1:0] {
    FLD_SEC  = 2'd0,
    FLD_MIN  = 2'd1,
    FLD_HR   = 2'd2,
    FLD_NONE = 2'd3
  } field_e;

  // Stage-1 command register
  logic   r_cmd_valid;
  logic   r_cmd_adjust;
  field_e r_cmd_field;
  logic   r_cmd_down;

  // Time state. Hours are kept as 0..23 in both modes, so the 12-hour walk is the 24-hour walk.
  logic [7:0] r_sec;
  logic [7:0] r_min;
  logic [4:0] r_hr;
  logic       r_day_pulse;

  logic       w_cmd_valid;
  logic [7:0] w_sec_nxt;
  logic [7:0] w_min_nxt;
  logic [4:0] w_hr_nxt;
  logic       w_day_nxt;
  logic [7:0] w_hr_bcd;

  // Step a two-digit BCD value in the range 00..59, with wraparound at both ends.
  function automatic logic [7:0] bcd59_step(input logic [7:0] v, input logic down);
    logic [3:0] t;
    logic [3:0] o;
    t = v[7:4];
    o = v[3:0];
    if (down) begin
      if (o == 4'd0) begin
        o = 4'd9;
        t = (t == 4'd0) ? 4'd5 : t - 4'd1;
      end else begin
        o = o - 4'd1;
      end
    end else begin
      if (o == 4'd9) begin
        o = 4'd0;
        t = (t == 4'd5) ? 4'd0 : t + 4'd1;
      end else begin
        o = o + 4'd1;
      end
    end
    return {t, o};
  endfunction

  function automatic logic [4:0] hr_step(input logic [4:0] h, input logic down);
    if (down) return (h == 5'd0)  ? 5'd23 : h - 5'd1;
    else      return (h == 5'd23) ? 5'd0  : h + 5'd1;
  endfunction

  function automatic logic [7:0] hr_to_bcd(input logic [4:0] h);
    logic [4:0] d;
    if (H24)             d = h;
    else if (h == 5'd0)  d = 5'd12;
    else if (h > 5'd12)  d = h - 5'd12;
    else                 d = h;
    if (d >= 5'd20)      return {4'd2, 4'(d - 5'd20)};
    else if (d >= 5'd10) return {4'd1, 4'(d - 5'd10)};
    else                 return {4'd0, d[3:0]};
  endfunction

  assign w_cmd_valid = i_tick & (i_adjust ? (i_adj_field != FLD_NONE) : i_count_enable);

  // NOTE: every variable gets a default at the top of the block, so no path can infer a latch.
  always_comb begin
    w_sec_nxt = r_sec;
    w_min_nxt = r_min;
    w_hr_nxt  = r_hr;
    w_day_nxt = 1'b0;
    if (r_cmd_valid) begin
      if (r_cmd_adjust) begin
        case (r_cmd_field)
          FLD_SEC: w_sec_nxt = bcd59_step(r_sec, r_cmd_down);
          FLD_MIN: w_min_nxt = bcd59_step(r_min, r_cmd_down);
          FLD_HR:  w_hr_nxt  = hr_step(r_hr, r_cmd_down);
          default: ;
        endcase
      end else begin
        w_sec_nxt = bcd59_step(r_sec, 1'b0);
        if (r_sec == 8'h59) begin
          w_min_nxt = bcd59_step(r_min, 1'b0);
          if (r_min == 8'h59) begin
            w_hr_nxt  = hr_step(r_hr, 1'b0);
            w_day_nxt = (r_hr == 5'd23);
          end
        end
      end
    end
    // Clearing the seconds drops the pending step entirely, including any minute carry.
    if (i_clear_sec) begin
      w_sec_nxt = 8'h00;
      w_min_nxt = r_min;
      w_hr_nxt  = r_hr;
      w_day_nxt = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_valid  <= 1'b0;
      r_cmd_adjust <= 1'b0;
      r_cmd_field  <= FLD_NONE;
      r_cmd_down   <= 1'b0;
      r_sec        <= 8'h00;
      r_min        <= 8'h00;
      r_hr         <= 5'd0;
      r_day_pulse  <= 1'b0;
    end else begin
      r_cmd_valid  <= w_cmd_valid;
      r_cmd_adjust <= i_adjust;
      r_cmd_field  <= field_e'(i_adj_field);
      r_cmd_down   <= i_adj_down;
      r_sec        <= w_sec_nxt;
      r_min        <= w_min_nxt;
      r_hr         <= w_hr_nxt;
      r_day_pulse  <= w_day_nxt;
    end
  end

  assign w_hr_bcd    = hr_to_bcd(r_hr);
  assign o_hr_tens   = w_hr_bcd[7:4];
  assign o_hr_ones   = w_hr_bcd[3:0];
  assign o_min_tens  = r_min[7:4];
  assign o_min_ones  = r_min[3:0];
  assign o_sec_tens  = r_sec[7:4];
  assign o_sec_ones  = r_sec[3:0];
  assign o_pm        = (r_hr >= 5'd12);
  assign o_day_pulse = r_day_pulse;

endmodule
